serial_adder_w: RTL and testbench
=================================

SERIAL_ADDER_W -- requirements
Module: serial_adder_w

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, legal range 2..32, serial word length in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port list, clock and reset first:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  bit-valid; the current operand bits are consumed on this edge.
- clr  input  1  synchronous word abort and restart.
- sub  input  1  mode: 0 = add, 1 = subtract (line1 - line2).
- line1  input  1  serial operand A, LSB first.
- line2  input  1  serial operand B, LSB first.
- outp  output  1  registered serial result bit.
- overflw  output  1  registered overflow flag, one-cycle pulse.
- word_done  output  1  registered end-of-word pulse.

Function
REQ-004 The block SHALL hold a bit counter cnt (ceil(log2(WIDTH)) bits), a carry register, and a latched mode register.
REQ-005 On an enabled edge with cnt==0, the effective mode SHALL be sub; the mode register SHALL capture sub; and the carry-in SHALL equal sub.
REQ-006 On an enabled edge with cnt!=0, the effective mode SHALL be the mode register, and the carry-in SHALL be the carry register; a change on sub mid-word SHALL be ignored.
REQ-007 Operand B' SHALL be line2 XOR effective mode; outp SHALL be loaded with line1 ^ B' ^ carry-in; the carry register SHALL be loaded with majority(line1, B', carry-in).
REQ-008 The result SHALL have one-cycle latency: outp reflects the bits sampled on the previous enabled edge.
REQ-009 cnt SHALL increment on each enabled edge and wrap from WIDTH-1 to 0.
REQ-010 On the enabled edge with cnt==WIDTH-1 (MSB edge), word_done SHALL be set to 1 and overflw SHALL be set per REQ-017; the carry register SHALL be cleared.
REQ-011 On every other edge, overflw and word_done SHALL be set to 0, so each is a single-cycle pulse.
REQ-012 When en=0, outp, cnt, carry and the mode register SHALL hold their values.
REQ-013 When clr=1, cnt, carry, outp, overflw and word_done SHALL be set to 0 on that edge regardless of en; clr SHALL take priority over en; the bit on that edge SHALL be discarded.
REQ-014 Back-to-back words SHALL need no idle cycle: the edge after the MSB edge SHALL be bit 0 of the next word.

Reset
REQ-015 While reset_n=0, outp, overflw, word_done, cnt, carry and the mode register SHALL be 0 immediately, independent of clock.
REQ-016 Reset asserted mid-word SHALL discard the partial word; the first enabled edge after release SHALL be bit 0.

Configuration
REQ-017 The macro SERIAL_ADDER_SIGNED_OVF_EN SHALL select how overflw is computed on the MSB edge:
- Defined: signed two's-complement overflow, carry-in XOR carry-out of the MSB.
- Undefined: unsigned overflow, carry-out XOR effective mode (carry for add, borrow for subtract).

Verification
REQ-018 The bench SHALL cover these directed scenarios, all with WIDTH=4:
- Add 7+1: line1 1,1,1,0 and line2 1,0,0,0, en=1 -> outp 0,0,0,1; word_done pulses once; overflw=0 when unsigned, overflw=1 when signed.
- Add 15+1: line1 1,1,1,1 and line2 1,0,0,0 -> outp 0,0,0,0; overflw=1 when unsigned, overflw=0 when signed.
- Subtract 3-5 with sub=1 at bit 0: line1 1,1,0,0 and line2 1,0,1,0 -> outp 0,1,1,1 (value 14); overflw=1 when unsigned (borrow), overflw=0 when signed.
- Stall: en=0 for 3 cycles between bits 1 and 2 of 7+1 -> same outp sequence; outputs hold during the stall; word_done is delayed 3 cycles.
- sub toggled at bit 2 during an add word -> result unchanged versus the constant-sub run.
- clr=1 with en=1 at bit 2, or reset_n pulsed low mid-word -> outp, overflw and word_done are 0; the next word 2+3 gives outp 1,0,1,0 with overflw=0.

Source files
------------

// File: rtl/serial_adder_w.sv
// Bit-serial adder/subtractor, LSB first, one-cycle result latency.
// Define SERIAL_ADDER_SIGNED_OVF_EN for signed overflow; default is unsigned carry/borrow.
module serial_adder_w #(
  parameter int WIDTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  input  logic sub,
  input  logic line1,
  input  logic line2,
  output logic outp,
  output logic overflw,
  output logic word_done
);

  localparam int CW = $clog2(WIDTH);

  // Input handshake: en is a pure valid with no ready; the block accepts
  // line1/line2/sub on every rising edge where en=1 (and clr=0).

  logic [CW-1:0] cnt;
  logic          carry;
  logic          mode_q;

  logic is_first;
  logic is_msb;
  logic eff_mode;
  logic cin;
  logic b_eff;
  logic sum_bit;
  logic cout;
  logic ovf_calc;

  always_comb begin
    is_first = (cnt == '0);
    is_msb   = (cnt == CW'(WIDTH - 1));
    eff_mode = is_first ? sub : mode_q;
    cin      = is_first ? sub : carry;
    b_eff    = line2 ^ eff_mode;
    sum_bit  = line1 ^ b_eff ^ cin;
    cout     = (line1 & b_eff) | (line1 & cin) | (b_eff & cin);
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    ovf_calc = cin ^ cout;
`else
    // Subtract is A + ~B + 1, so a missing carry-out means a borrow.
    ovf_calc = cout ^ eff_mode;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      carry     <= 1'b0;
      mode_q    <= 1'b0;
      outp      <= 1'b0;
      overflw   <= 1'b0;
      word_done <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      carry     <= 1'b0;
      outp      <= 1'b0;
      overflw   <= 1'b0;
      word_done <= 1'b0;
    end else if (en) begin
      outp <= sum_bit;
      if (is_first) mode_q <= sub;
      if (is_msb) begin
        cnt       <= '0;
        carry     <= 1'b0;
        word_done <= 1'b1;
        overflw   <= ovf_calc;
      end else begin
        cnt       <= cnt + CW'(1);
        carry     <= cout;
        word_done <= 1'b0;
        overflw   <= 1'b0;
      end
    end else begin
      overflw   <= 1'b0;
      word_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_adder_w.sv
// Self-checking bench for serial_adder_w: directed cases plus random words
// against an integer-arithmetic reference model.
module tb_serial_adder_w;

  localparam int W = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic sub = 1'b0;
  logic line1 = 1'b0;
  logic line2 = 1'b0;
  logic outp;
  logic overflw;
  logic word_done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic         ovf_q[$];

  serial_adder_w #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .clr       (clr),
    .sub       (sub),
    .line1     (line1),
    .line2     (line2),
    .outp      (outp),
    .overflw   (overflw),
    .word_done (word_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-word integer arithmetic.
  task automatic model(input int a, input int b, input logic s);
    int r;
    int sa;
    int sb;
    int sr;
    logic o;
    r  = s ? (a - b) : (a + b);
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sr = s ? (sa - sb) : (sa + sb);
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
`else
    o = s ? (a < b) : (a + b > (1 << W) - 1);
`endif
    exp_q.push_back(r[W-1:0]);
    ovf_q.push_back(o);
  endtask

  // Called at a negedge: apply inputs, take one rising edge, return at the next negedge.
  task automatic edge_in(input logic l1, input logic l2, input logic s, input logic e, input logic c);
    line1 = l1;
    line2 = l2;
    sub   = s;
    en    = e;
    clr   = c;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_word(input int a, input int b, input logic s,
                          input int toggle_bit, input int stall_bit, input int stall_len);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] r;
    logic         o;
    av = a[W-1:0];
    bv = b[W-1:0];
    model(a, b, s);
    r = exp_q.pop_front();
    o = ovf_q.pop_front();
    for (int i = 0; i < W; i++) begin
      if (i == stall_bit && i > 0) begin
        for (int k = 0; k < stall_len; k++) begin
          edge_in(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
          check("stall_outp", outp, r[i-1]);
          check("stall_done", word_done, 0);
          check("stall_ovf", overflw, 0);
        end
      end
      edge_in(av[i], bv[i], (i >= toggle_bit) ? ~s : s, 1'b1, 1'b0);
      check("outp", outp, r[i]);
      check("word_done", word_done, (i == W - 1) ? 1 : 0);
      check("overflw", overflw, (i == W - 1) ? o : 1'b0);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_outp", outp, 0);
    check("rst_done", word_done, 0);
    check("rst_ovf", overflw, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed cases
    run_word(7, 1, 1'b0, 99, 99, 0);
    run_word(15, 1, 1'b0, 99, 99, 0);
    run_word(3, 5, 1'b1, 99, 99, 0);
    run_word(7, 1, 1'b0, 99, 2, 3);
    run_word(7, 1, 1'b0, 2, 99, 0);
    run_word(3, 5, 1'b1, 2, 1, 2);

    // clr with en=1 at bit 2 of 6+1
    edge_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    edge_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_clr_outp", outp, 1);
    edge_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_outp", outp, 0);
    check("clr_done", word_done, 0);
    check("clr_ovf", overflw, 0);
    run_word(2, 3, 1'b0, 99, 99, 0);

    // Asynchronous reset mid-word of 5+0
    edge_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_rst_outp", outp, 1);
    edge_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_outp", outp, 0);
    check("async_rst_done", word_done, 0);
    check("async_rst_ovf", overflw, 0);
    @(negedge clock);
    reset_n = 1'b1;
    run_word(2, 3, 1'b0, 99, 99, 0);

    // Random back-to-back words with random mode, stalls and mid-word sub toggles
    for (int n = 0; n < 40; n++) begin
      run_word(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
               1'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, W - 1)),
               int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
